// File: rtl/mem_grant_dispatcher.sv
// Single-transaction dispatcher between the round-robin arbiter and the memory interface.
// Captures the granted port's command, issues it with valid/ready, and returns done/err/rdata.
module mem_grant_dispatcher #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          grant,
  input  logic [4*ADDR_W-1:0] port_addr,
  input  logic [4*DATA_W-1:0] port_wdata,
  input  logic [3:0]          port_we,
  output logic [3:0]          port_done,
  output logic [3:0]          port_err,
  output logic [DATA_W-1:0]   port_rdata,
  output logic                busy,
  output logic                grant_err,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_we,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              gerr_q, gerr_d;

  logic       grant_any;
  logic       grant_multi;
  logic [1:0] grant_idx;

  // x & (x-1) clears the lowest set bit; anything left means more than one bit was set.
  assign grant_any   = |grant;
  assign grant_multi = |(grant & (grant - 4'd1));

  always_comb begin
    grant_idx = 2'd0;
    case (grant)
      4'b0010: grant_idx = 2'd1;
      4'b0100: grant_idx = 2'd2;
      4'b1000: grant_idx = 2'd3;
      default: grant_idx = 2'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    gerr_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (grant_multi) begin
          gerr_d = 1'b1;
        end else if (grant_any) begin
          state_d = StIssue;
          idx_d   = grant_idx;
          addr_d  = port_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
          wdata_d = port_wdata[int'(grant_idx)*DATA_W +: DATA_W];
          we_d    = port_we[grant_idx];
          cnt_d   = '0;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      StIssue: begin
        if (mem_ready) begin
          state_d = StWait;
          cnt_d   = '0;
        end
      end
      StWait: begin
        // Completion takes priority over a timeout landing on the same edge.
        if (mem_rvalid) begin
          state_d = StResp;
          rdata_d = we_q ? '0 : mem_rdata;
          err_d   = 1'b0;
        end else if (cnt_q == CntMax) begin
          state_d = StResp;
          rdata_d = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      gerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      gerr_q  <= gerr_d;
    end
  end

  // Decoded straight from state so that reset removes mem_valid and busy without a clock.
  always_comb begin
    busy       = (state_q != StIdle);
    mem_valid  = (state_q == StIssue);
    mem_addr   = addr_q;
    mem_wdata  = wdata_q;
    mem_we     = we_q;
    grant_err  = gerr_q;
    port_done  = 4'b0000;
    port_err   = 4'b0000;
    port_rdata = '0;
    if (state_q == StResp) begin
      port_done[idx_q] = 1'b1;
      port_err[idx_q]  = err_q;
      port_rdata       = rdata_q;
    end
  end

endmodule

// File: tb/tb_mem_grant_dispatcher.sv
// Directed bench for mem_grant_dispatcher: transaction-level model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_mem_grant_dispatcher;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 64;

  logic                clk = 1'b0;
  logic                rst;
  logic [3:0]          grant;
  logic [4*ADDR_W-1:0] port_addr;
  logic [4*DATA_W-1:0] port_wdata;
  logic [3:0]          port_we;
  logic [3:0]          port_done;
  logic [3:0]          port_err;
  logic [DATA_W-1:0]   port_rdata;
  logic                busy;
  logic                grant_err;
  logic                mem_valid;
  logic                mem_ready;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_we;
  logic                mem_rvalid;
  logic [DATA_W-1:0]   mem_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_grant_dispatcher #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .grant     (grant),
    .port_addr (port_addr),
    .port_wdata(port_wdata),
    .port_we   (port_we),
    .port_done (port_done),
    .port_err  (port_err),
    .port_rdata(port_rdata),
    .busy      (busy),
    .grant_err (grant_err),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: who owns the dispatcher, whether the command was accepted,
  // how many edges have passed since acceptance, and whether this cycle is the response.
  typedef struct packed {
    logic              active;
    logic [1:0]        port;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              we;
    logic              accepted;
    logic [7:0]        elapsed;
    logic              resp;
    logic              err;
    logic [DATA_W-1:0] rdata;
    logic              gerr;
  } model_t;

  model_t m, m_next;

  always_comb begin
    m_next      = m;
    m_next.gerr = 1'b0;
    if (m.resp) begin
      m_next.resp   = 1'b0;
      m_next.active = 1'b0;
    end else if (!m.active) begin
      if ($countones(grant) > 1) begin
        m_next.gerr = 1'b1;
      end else if ($countones(grant) == 1) begin
        m_next.active   = 1'b1;
        m_next.accepted = 1'b0;
        for (int i = 0; i < 4; i++) begin
          if (grant[i]) begin
            m_next.port  = 2'(i);
            m_next.addr  = port_addr[i*ADDR_W +: ADDR_W];
            m_next.wdata = port_wdata[i*DATA_W +: DATA_W];
            m_next.we    = port_we[i];
          end
        end
      end
    end else if (!m.accepted) begin
      if (mem_ready) begin
        m_next.accepted = 1'b1;
        m_next.elapsed  = 8'd0;
      end
    end else begin
      m_next.elapsed = m.elapsed + 8'd1;
      if (mem_rvalid) begin
        m_next.resp  = 1'b1;
        m_next.err   = 1'b0;
        m_next.rdata = m.we ? '0 : mem_rdata;
      end else if (m_next.elapsed == 8'(TIMEOUT)) begin
        m_next.resp  = 1'b1;
        m_next.err   = 1'b1;
        m_next.rdata = '0;
      end
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '0;
    else     m <= m_next;
  end

  // Every-cycle comparison, mid-cycle.
  always @(negedge clk) begin
    logic [3:0] exp_done;
    exp_done = m.resp ? (4'b0001 << m.port) : 4'b0000;
    check("busy", 64'(busy), 64'(m.active));
    check("mem_valid", 64'(mem_valid), 64'(m.active && !m.accepted));
    if (m.active && !m.accepted) begin
      check("mem_addr", 64'(mem_addr), 64'(m.addr));
      check("mem_wdata", 64'(mem_wdata), 64'(m.wdata));
      check("mem_we", 64'(mem_we), 64'(m.we));
    end
    check("port_done", 64'(port_done), 64'(exp_done));
    check("port_err", 64'(port_err), 64'(m.err ? exp_done : 4'b0000));
    check("port_rdata", 64'(port_rdata), 64'(m.resp ? m.rdata : '0));
    check("grant_err", 64'(grant_err), 64'(m.gerr));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for a done pulse; returns the number of edges taken, or -1 on budget expiry.
  task automatic wait_done(input int budget, output int edges);
    edges = -1;
    for (int k = 1; k <= budget; k++) begin
      tick();
      if (port_done != 4'b0000) begin
        edges = k;
        break;
      end
    end
    if (edges < 0) check("done_timeout", 64'(edges), 64'(0));
  endtask

  initial begin
    int n;
    rst        = 1'b1;
    grant      = 4'b0000;
    port_addr  = '0;
    port_wdata = '0;
    port_we    = 4'b0000;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    #2;
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_valid", 64'(mem_valid), 64'(0));
    check("reset_done", 64'(port_done), 64'(0));
    check("reset_rdata", 64'(port_rdata), 64'(0));
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Read on port 2, completion two edges after acceptance.
    port_addr[2*ADDR_W +: ADDR_W] = 16'h1234;
    port_we   = 4'b0000;
    mem_ready = 1'b1;
    grant     = 4'b0100;
    tick();
    grant = 4'b0000;
    check("t1_valid", 64'(mem_valid), 64'(1));
    check("t1_addr", 64'(mem_addr), 64'h1234);
    check("t1_we", 64'(mem_we), 64'(0));
    tick();
    check("t1_wait_valid", 64'(mem_valid), 64'(0));
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEADBEEF;
    tick();
    mem_rvalid = 1'b0;
    check("t1_done", 64'(port_done), 64'b0100);
    check("t1_rdata", 64'(port_rdata), 64'hDEADBEEF);
    tick();
    check("t1_idle", 64'(busy), 64'(0));

    // Write on port 0 with three cycles of backpressure.
    port_addr[0 +: ADDR_W]   = 16'h0042;
    port_wdata[0 +: DATA_W]  = 32'hA5A5A5A5;
    port_we    = 4'b0001;
    mem_ready  = 1'b0;
    grant      = 4'b0001;
    tick();
    grant = 4'b0000;
    port_wdata[0 +: DATA_W] = 32'h12345678;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      if (mem_valid) n++;
      tick();
    end
    mem_ready = 1'b1;
    if (mem_valid) n++;
    check("t2_wdata_held", 64'(mem_wdata), 64'hA5A5A5A5);
    tick();
    mem_ready = 1'b0;
    check("t2_valid_cycles", 64'(n), 64'(4));
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hFFFFFFFF;
    tick();
    mem_rvalid = 1'b0;
    check("t2_done", 64'(port_done), 64'b0001);
    check("t2_rdata", 64'(port_rdata), 64'(0));
    tick();
    port_we = 4'b0000;

    // Grant for port 3 while port 1 is waiting is ignored; it is served afterwards.
    port_addr[1*ADDR_W +: ADDR_W] = 16'h0111;
    port_addr[3*ADDR_W +: ADDR_W] = 16'h0333;
    mem_ready = 1'b1;
    grant     = 4'b0010;
    tick();
    grant = 4'b0000;
    tick();
    grant = 4'b1000;
    tick();
    tick();
    check("t3_ignored", 64'(mem_valid), 64'(0));
    check("t3_addr", 64'(mem_addr), 64'h0111);
    grant      = 4'b0000;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h11111111;
    tick();
    mem_rvalid = 1'b0;
    check("t3_done1", 64'(port_done), 64'b0010);
    grant = 4'b1000;
    tick();
    tick();
    grant = 4'b0000;
    check("t3_addr3", 64'(mem_addr), 64'h0333);
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h33333333;
    wait_done(10, n);
    mem_rvalid = 1'b0;
    check("t3_done3", 64'(port_done), 64'b1000);
    tick();

    // Timeout: no completion, done+err exactly TIMEOUT edges after acceptance.
    grant = 4'b0001;
    tick();
    grant = 4'b0000;
    tick();
    wait_done(200, n);
    check("t4_latency", 64'(n), 64'(64));
    check("t4_err", 64'(port_err), 64'b0001);
    check("t4_rdata", 64'(port_rdata), 64'(0));
    tick();
    // Completion on the timeout edge wins.
    grant = 4'b0001;
    tick();
    grant = 4'b0000;
    tick();
    for (int i = 0; i < 63; i++) tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0BADF00D;
    tick();
    mem_rvalid = 1'b0;
    check("t4b_done", 64'(port_done), 64'b0001);
    check("t4b_err", 64'(port_err), 64'(0));
    check("t4b_rdata", 64'(port_rdata), 64'h0BADF00D);
    tick();

    // Multi-hot grant.
    grant = 4'b0110;
    tick();
    grant = 4'b0000;
    check("t5_gerr", 64'(grant_err), 64'(1));
    check("t5_valid", 64'(mem_valid), 64'(0));
    check("t5_busy", 64'(busy), 64'(0));
    tick();
    check("t5_gerr_pulse", 64'(grant_err), 64'(0));

    // Reset while issuing, then a normal transaction.
    mem_ready = 1'b0;
    grant     = 4'b0001;
    tick();
    grant = 4'b0000;
    check("t6_issue", 64'(mem_valid), 64'(1));
    rst = 1'b1;
    #1;
    check("t6_valid_drop", 64'(mem_valid), 64'(0));
    check("t6_busy_drop", 64'(busy), 64'(0));
    check("t6_no_done", 64'(port_done), 64'(0));
    tick();
    rst = 1'b0;
    tick();
    mem_ready = 1'b1;
    grant     = 4'b0001;
    tick();
    grant      = 4'b0000;
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFEF00D;
    wait_done(10, n);
    mem_rvalid = 1'b0;
    check("t6_done", 64'(port_done), 64'b0001);
    check("t6_rdata", 64'(port_rdata), 64'hCAFEF00D);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
